// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - command sequencer driving the accumulator ALU strobes; define SEQ_SPLIT_LOAD_EN for two-phase LOAD
module alu_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_kind,
    input  logic [4:0]  cmd_aluop,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [4:0]  alu_opcode,
    output logic [15:0] alu_operand,
    output logic        alu_write,
    output logic        alu_writeu,
    output logic        alu_read,
    input  logic [15:0] alu_accout,
    input  logic        alu_flag
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_LO,
        S_LOAD_HI,
        S_EXEC,
        S_READ,
        S_TEST,
        S_RESP
    } state_t;

    state_t      state, state_next;
    logic [4:0]  aluop_q;
    logic [15:0] data_q;
    logic [15:0] rsp_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            aluop_q    <= 5'b00000;
            data_q     <= 16'h0000;
            rsp_data_q <= 16'h0000;
        end else begin
            state <= state_next;
            if (state == S_IDLE && cmd_valid) begin
                aluop_q <= cmd_aluop;
                data_q  <= cmd_data;
            end
            // Response is captured in the same cycle the ALU drives accout.
            if (state == S_READ) begin
                rsp_data_q <= alu_accout;
            end else if (state == S_TEST) begin
                rsp_data_q <= {15'h0000, alu_flag};
            end
        end
    end

    assign rsp_data = rsp_data_q;

    always_comb begin
        state_next  = state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_opcode  = 5'b00000;
        alu_operand = 16'h0000;
        alu_write   = 1'b0;
        alu_writeu  = 1'b0;
        alu_read    = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    case (cmd_kind)
                        2'd0:    state_next = S_LOAD_LO;
                        2'd1:    state_next = S_EXEC;
                        2'd2:    state_next = S_READ;
                        default: state_next = S_TEST;
                    endcase
                end
            end
            S_LOAD_LO: begin
                alu_write = 1'b1;
`ifdef SEQ_SPLIT_LOAD_EN
                alu_operand = {4'h0, data_q[11:0]};
                state_next  = S_LOAD_HI;
`else
                alu_operand = data_q;
                state_next  = S_IDLE;
`endif
            end
`ifdef SEQ_SPLIT_LOAD_EN
            S_LOAD_HI: begin
                alu_writeu  = 1'b1;
                alu_operand = {12'h000, data_q[15:12]};
                state_next  = S_IDLE;
            end
`endif
            S_EXEC: begin
                alu_opcode  = aluop_q;
                alu_operand = data_q;
                state_next  = S_IDLE;
            end
            S_READ: begin
                alu_read   = 1'b1;
                state_next = S_RESP;
            end
            S_TEST: begin
                state_next = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed and random checks of alu_sequencer against an accumulator model
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_kind;
    logic [4:0]  cmd_aluop;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [4:0]  alu_opcode;
    logic [15:0] alu_operand;
    logic        alu_write;
    logic        alu_writeu;
    logic        alu_read;
    logic [15:0] alu_accout;
    logic        alu_flag;

    int total = 0;
    int bad   = 0;
    bit running = 1'b0;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_CE  = 5'b01100;

    // Expected accumulator and flag, derived purely from the command stream.
    logic [15:0] exp_acc  = 16'h0000;
    logic        exp_flag = 1'b0;

    // Stand-in ALU: reacts only to the sequencer's strobes.
    logic [15:0] acc_reg  = 16'h0000;
    logic        flag_reg = 1'b0;

    alu_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_aluop  (cmd_aluop),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_opcode (alu_opcode),
        .alu_operand(alu_operand),
        .alu_write  (alu_write),
        .alu_writeu (alu_writeu),
        .alu_read   (alu_read),
        .alu_accout (alu_accout),
        .alu_flag   (alu_flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_write) acc_reg <= alu_operand;
        else if (alu_writeu) acc_reg[15:12] <= alu_operand[3:0];
        else begin
            case (alu_opcode)
                OP_ADD:  acc_reg <= acc_reg + alu_operand;
                OP_SUB:  acc_reg <= acc_reg - alu_operand;
                OP_CE:   flag_reg <= (acc_reg == alu_operand);
                default: ;
            endcase
        end
    end

    assign alu_accout = alu_read ? acc_reg : 16'h0000;
    assign alu_flag   = flag_reg;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (running && !rst)
            check("one_active", 16'($countones({alu_write, alu_writeu, alu_read, alu_opcode != 5'b00000}) <= 1), 16'h0001);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ready"}, 16'(cmd_ready), 16'h0001);
        check({tag, "_strobes"}, 16'({alu_write, alu_writeu, alu_read}), 16'h0000);
        check({tag, "_opcode"}, 16'(alu_opcode), 16'h0000);
        check({tag, "_operand"}, alu_operand, 16'h0000);
        check({tag, "_rsp_valid"}, 16'(rsp_valid), 16'h0000);
    endtask

    // Present one command in IDLE; returns in cycle N+1 with junk on cmd_*.
    task automatic issue(input logic [1:0] kind, input logic [4:0] op, input logic [15:0] d);
        check("accept_ready", 16'(cmd_ready), 16'h0001);
        cmd_valid = 1'b1;
        cmd_kind  = kind;
        cmd_aluop = op;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_kind  = 2'($urandom);
        cmd_aluop = 5'($urandom);
        cmd_data  = 16'($urandom);
    endtask

    task automatic do_load(input logic [15:0] d);
        issue(2'd0, 5'($urandom), d);
        check("load_lo_strobes", 16'({alu_write, alu_writeu, alu_read}), 16'h0004);
        check("load_lo_opcode", 16'(alu_opcode), 16'h0000);
        check("load_lo_busy", 16'(cmd_ready), 16'h0000);
`ifdef SEQ_SPLIT_LOAD_EN
        check("load_lo_operand", alu_operand, {4'h0, d[11:0]});
        step();
        check("load_hi_strobes", 16'({alu_write, alu_writeu, alu_read}), 16'h0002);
        check("load_hi_operand", alu_operand, {12'h000, d[15:12]});
        check("load_hi_busy", 16'(cmd_ready), 16'h0000);
`else
        check("load_operand", alu_operand, d);
`endif
        step();
        check_quiet("load_done");
        exp_acc = d;
    endtask

    task automatic do_exec(input logic [4:0] op, input logic [15:0] d);
        issue(2'd1, op, d);
        check("exec_opcode", 16'(op == 5'b00000 ? alu_opcode : alu_opcode), 16'(op));
        check("exec_operand", alu_operand, d);
        check("exec_strobes", 16'({alu_write, alu_writeu, alu_read}), 16'h0000);
        check("exec_busy", 16'(cmd_ready), 16'h0000);
        step();
        check_quiet("exec_done");
        case (op)
            OP_ADD:  exp_acc = exp_acc + d;
            OP_SUB:  exp_acc = exp_acc - d;
            OP_CE:   exp_flag = (exp_acc == d);
            default: ;
        endcase
    endtask

    // kind 2 = READ, 3 = TEST; hold = cycles rsp_ready stays low in RESP.
    task automatic do_query(input logic [1:0] kind, input int hold);
        logic [15:0] want;
        want = (kind == 2'd2) ? exp_acc : {15'h0000, exp_flag};
        issue(kind, 5'($urandom), 16'($urandom));
        check("query_strobes", 16'({alu_write, alu_writeu, alu_read}), (kind == 2'd2) ? 16'h0001 : 16'h0000);
        check("query_early_valid", 16'(rsp_valid), 16'h0000);
        step();
        check("rsp_valid", 16'(rsp_valid), 16'h0001);
        check(kind == 2'd2 ? "read_data" : "test_data", rsp_data, want);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_valid", 16'(rsp_valid), 16'h0001);
            check("hold_data", rsp_data, want);
            check("hold_busy", 16'(cmd_ready), 16'h0000);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_quiet("rsp_done");
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_kind = 2'd0;
        cmd_aluop = 5'd0;
        cmd_data = 16'h0000;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        running = 1'b1;
        check_quiet("reset");
        check("reset_rsp_data", rsp_data, 16'h0000);

        do_load(16'hBEEF);
        do_query(2'd2, 0);

        do_load(16'h1234);
        do_exec(OP_ADD, 16'h0011);
        do_query(2'd2, 0);

        do_load(16'h1245);
        do_exec(OP_CE, 16'h1245);
        do_query(2'd3, 0);
        do_exec(OP_CE, 16'h1244);
        do_query(2'd3, 0);

        do_query(2'd2, 3);

        // Reset while LOAD_LO is on the ALU: the write lands, nothing follows.
        issue(2'd0, 5'd0, 16'hBEEF);
        rst = 1'b1;
        step();
        rst = 1'b0;
`ifdef SEQ_SPLIT_LOAD_EN
        exp_acc = 16'h0EEF;
`else
        exp_acc = 16'hBEEF;
`endif
        check_quiet("rst_load");
        check("rst_load_rsp_data", rsp_data, 16'h0000);
        step();
        check_quiet("rst_load_after");
        do_query(2'd2, 0);

        // Reset while a response is pending discards it.
        issue(2'd3, 5'd0, 16'h0000);
        step();
        check("pre_rst_valid", 16'(rsp_valid), 16'h0001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_quiet("rst_resp");
        check("rst_resp_data", rsp_data, 16'h0000);

        for (int n = 0; n < 60; n++) begin
            logic [4:0] ops [5];
            ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_CE; ops[3] = 5'b00000; ops[4] = 5'b11111;
            case ($urandom_range(0, 3))
                0: do_load(16'($urandom));
                1: do_exec(ops[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0) ? exp_acc : 16'($urandom));
                2: do_query(2'd2, $urandom_range(0, 3));
                default: do_query(2'd3, $urandom_range(0, 3));
            endcase
        end

        running = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
